mul_share_arbiter: RTL and testbench

//  - Shares one iterative 32x32 shift-add multiplier between NUM_REQ requesters.
//  - Round-robin grant; latches the winner's operands, loads and starts the multiplier,

---
 rtl/mul_arb_pkg.sv | 26 ++
 rtl/mul_share_arbiter_rr_picker.sv | 38 +++
 rtl/mul_share_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   - FSM state encoding used by mul_share_arbiter
//   - default parameter values (requester count, operand width, watchdog limit)
//   - round-robin index helper used by rr_picker
package mul_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_TIMEOUT = 40;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Requester index reached by stepping offs positions past ptr, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned offs,
                                            input int unsigned n);
        return (ptr + offs) % n;
    endfunction

endpackage : mul_arb_pkg

// File: rtl/mul_share_arbiter_rr_picker.sv
// Combinational round-robin priority select.
// Ports:
//   req      - request vector, one bit per requester
//   ptr      - index of the last granted requester; search starts at ptr+1
//   grant_c  - one-hot grant (all zero when no request)
//   idx_c    - binary index of the granted requester
//   any_c    - at least one request present
module rr_picker
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    // Walk ptr+1 .. ptr+NUM_REQ (wrapping) and keep the first requester found;
    // the last position visited is ptr itself, so it has lowest priority.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned j;
            j = rr_next(32'(ptr), i, NUM_REQ);
            if (!any_c && req[j]) begin
                any_c      = 1'b1;
                grant_c[j] = 1'b1;
                idx_c      = IDX_W'(j);
            end
        end
    end

endmodule : rr_picker

// File: rtl/mul_share_arbiter.sv
// Shares one iterative multiplier between NUM_REQ requesters.
// A round-robin winner's operands are latched, the multiplier is loaded and run,
// and the 2*WIDTH-bit product is returned to that requester on a shared bus.
//
// Build option: define MUL_ARB_WATCHDOG_EN to abort a job that waits TIMEOUT
// cycles for mul_ready; the response then carries product 0 with resp_err=1.
// Without it WAIT blocks until mul_ready and resp_err stays 0.
//
// Ports:
//   clk, Reset                 - clock (rising edge), async active-low reset
//   req_valid/req_ready        - per-requester request; req_ready is a one-hot accept
//   req_mcand/req_mplier       - packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready      - one-hot result valid to the owner, owner's accept
//   resp_product, resp_err     - shared result bus, qualified by resp_valid
//   mul_mcand/mul_mplier       - latched operands to the multiplier
//   mul_load, mul_run          - multiplier load pulse and run level
//   mul_ready, mul_product     - multiplier done flag and product
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_mcand,
    input  logic [NUM_REQ*WIDTH-1:0] req_mplier,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     resp_err,
    output logic [WIDTH-1:0]         mul_mcand,
    output logic [WIDTH-1:0]         mul_mplier,
    output logic                     mul_load,
    output logic                     mul_run,
    input  logic                     mul_ready,
    input  logic [2*WIDTH-1:0]       mul_product
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("mul_share_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mul_share_arbiter: TIMEOUT must be at least 1");
    end

    state_t              state_q;
    state_t              state_d;
    logic                req_en_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0]  owner_oh_q;
    logic                grant_en;
    logic                wd_expire;

    logic [NUM_REQ-1:0]  pick_grant_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic                pick_any_c;
    logic [WIDTH-1:0]    sel_mcand;
    logic [WIDTH-1:0]    sel_mplier;

    // Round-robin select among current requests, starting after the last winner.
    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // One-hot operand mux for the candidate winner.
    always_comb begin
        sel_mcand  = '0;
        sel_mplier = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant_c[i]) begin
                sel_mcand  = req_mcand[i*WIDTH +: WIDTH];
                sel_mplier = req_mplier[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUL_ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q;

    // Fires on the TIMEOUT-th consecutive WAIT cycle without mul_ready.
    assign wd_expire = (state_q == ST_WAIT) && !mul_ready &&
                       (wd_cnt_q == CNT_W'(TIMEOUT - 1));

    // Watchdog counter: runs only in WAIT, cleared in every other state.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wd_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            wd_cnt_q <= '0;
        end else if (!mul_ready && !wd_expire) begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the combinational accept.
    // req_ready must answer req_valid in the same cycle, so it is decoded here;
    // req_en_q keeps it low until the first clock after reset release.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        grant_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_en_q && pick_any_c) begin
                    grant_en  = 1'b1;
                    req_ready = pick_grant_c;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (mul_ready || wd_expire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[rr_ptr_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            req_en_q   <= 1'b0;
            mul_load   <= 1'b0;
            mul_run    <= 1'b0;
            resp_valid <= '0;
        end else begin
            req_en_q   <= 1'b1;
            // Timeout reuses the load pulse to quiesce the multiplier.
            mul_load   <= (state_d == ST_LOAD) || wd_expire;
            mul_run    <= (state_d == ST_RUN) || (state_d == ST_WAIT);
            resp_valid <= (state_d == ST_RESP) ? owner_oh_q : '0;
        end
    end

    // Job context: winner, operands and result.
    // rr_ptr_q doubles as the owner index of the job in flight.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            owner_oh_q   <= '0;
            mul_mcand    <= '0;
            mul_mplier   <= '0;
            resp_product <= '0;
            resp_err     <= 1'b0;
        end else begin
            if (grant_en) begin
                rr_ptr_q   <= pick_idx_c;
                owner_oh_q <= pick_grant_c;
                mul_mcand  <= sel_mcand;
                mul_mplier <= sel_mplier;
            end
            if (state_q == ST_WAIT && mul_ready) begin
                resp_product <= mul_product;
                resp_err     <= 1'b0;
            end else if (wd_expire) begin
                resp_product <= '0;
                resp_err     <= 1'b1;
            end
        end
    end

endmodule : mul_share_arbiter

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter with a behavioural multiplier model.
`timescale 1ns/1ps
module tb_mul_share_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned TIMEOUT  = 40;
    localparam int unsigned MUL_ITER = 5;

    logic                     clk = 1'b0;
    logic                     Reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_mcand;
    logic [NUM_REQ*WIDTH-1:0] req_mplier;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [2*WIDTH-1:0]       resp_product;
    logic                     resp_err;
    logic [WIDTH-1:0]         mul_mcand;
    logic [WIDTH-1:0]         mul_mplier;
    logic                     mul_load;
    logic                     mul_run;
    logic                     mul_ready;
    logic [2*WIDTH-1:0]       mul_product;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mcand    (req_mcand),
        .req_mplier   (req_mplier),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_err     (resp_err),
        .mul_mcand    (mul_mcand),
        .mul_mplier   (mul_mplier),
        .mul_load     (mul_load),
        .mul_run      (mul_run),
        .mul_ready    (mul_ready),
        .mul_product  (mul_product)
    );

    // Multiplier model: MUL_ITER run cycles after a load, then ready with the product.
    logic              stuck;
    int unsigned       m_cnt;
    logic [63:0]       m_acc;
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            m_cnt       <= 0;
            m_acc       <= '0;
            mul_ready   <= 1'b0;
            mul_product <= '0;
        end else if (mul_load) begin
            m_acc       <= 64'(mul_mcand) * 64'(mul_mplier);
            m_cnt       <= MUL_ITER;
            mul_ready   <= 1'b0;
            mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (mul_run && !stuck && m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_ready   <= 1'b1;
                mul_product <= m_acc;
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          idx;
        logic [63:0] prod;
        logic        err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   grant_log[$];
    logic expect_timeout = 1'b0;

    logic [NUM_REQ-1:0] s_acc, s_req_ready, s_resp_valid;
    logic [63:0]        s_resp_product;
    logic               s_resp_err, s_mul_load, s_mul_run;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic v);
        req_mcand[id*WIDTH +: WIDTH]  = a;
        req_mplier[id*WIDTH +: WIDTH] = b;
        req_valid[id]                 = v;
    endtask

    // One cycle: sample at the falling edge, run the scoreboard, return at posedge+1.
    task automatic step();
        logic [NUM_REQ-1:0] done;
        exp_t e;
        @(negedge clk);
        s_req_ready    = req_ready;
        s_resp_valid   = resp_valid;
        s_resp_product = resp_product;
        s_resp_err     = resp_err;
        s_mul_load     = mul_load;
        s_mul_run      = mul_run;
        s_acc          = req_valid & req_ready;
        if (s_acc != 0) begin
            check("req_ready_onehot", 64'($countones(s_acc)), 64'(1));
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (s_acc[i]) begin
                    e.idx  = i;
                    e.err  = expect_timeout;
                    e.prod = expect_timeout ? 64'(0) :
                             64'(req_mcand[i*WIDTH +: WIDTH]) * 64'(req_mplier[i*WIDTH +: WIDTH]);
                end
            end
            sb.push_back(e);
            grant_log.push_back(e.idx);
        end
        done = resp_valid & resp_ready;
        if (done != 0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_resp", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                check("sb_owner", 64'(resp_valid), 64'(1) << e.idx);
                check("sb_product", resp_product, e.prod);
                check("sb_err", 64'(resp_err), 64'(e.err));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int id, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_acc[id]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'(1));
    endtask

    // Cycles from the grant sample to the first resp_valid sample (-1 on timeout).
    task automatic wait_resp(input int max, output int lat, output int nload);
        lat   = -1;
        nload = 0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (s_mul_load) nload++;
            if (s_resp_valid != 0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        check("drain_empty", 64'(sb.size()), 64'(0));
        step();
        step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        Reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b1;
        sb.delete();
        grant_log.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        check({tag, "_resp_product"}, resp_product, 64'(0));
        check({tag, "_resp_err"}, 64'(resp_err), 64'(0));
        check({tag, "_mul_load"}, 64'(mul_load), 64'(0));
        check({tag, "_mul_run"}, 64'(mul_run), 64'(0));
        check({tag, "_mul_mcand"}, 64'(mul_mcand), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t        vecs[6];
        int          lat, nload;
        logic [63:0] held;

        vecs[0] = '{id: 0, a: 32'd3,          b: 32'd5,          exp: 64'd15};
        vecs[1] = '{id: 1, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{id: 2, a: 32'd0,          b: 32'h1234_5678,  exp: 64'd0};
        vecs[3] = '{id: 3, a: 32'h8000_0000,  b: 32'd2,          exp: 64'h1_0000_0000};
        vecs[4] = '{id: 0, a: 32'hFFFF_FFFF,  b: 32'd2,          exp: 64'h1_FFFF_FFFE};
        vecs[5] = '{id: 1, a: 32'd12345,      b: 32'd6789,       exp: 64'd83810205};

        Reset      = 1'b0;
        stuck      = 1'b0;
        req_valid  = '0;
        req_mcand  = '0;
        req_mplier = '0;
        resp_ready = '1;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b1;
        step();

        // Table-driven single jobs.
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, 1'b1);
            wait_grant(vecs[v].id, $sformatf("vec%0d_grant", v));
            req_valid[vecs[v].id] = 1'b0;
            wait_resp(40, lat, nload);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(3 + MUL_ITER));
            check($sformatf("vec%0d_load_pulses", v), 64'(nload), 64'(1));
            check($sformatf("vec%0d_resp_valid", v), 64'(s_resp_valid), 64'(1) << vecs[v].id);
            check($sformatf("vec%0d_product", v), s_resp_product, vecs[v].exp);
            check($sformatf("vec%0d_err", v), 64'(s_resp_err), 64'(0));
            step();
        end
        drain();

        // Contention: all four held valid from reset -> 0,1,2,3,0.
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 2), 32'(10 * i + 7), 1'b1);
        do_reset();
        for (int i = 0; i < 300 && grant_log.size() < 5; i++) step();
        req_valid = '0;
        check("contention_count", 64'(grant_log.size()), 64'(5));
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check($sformatf("contention_grant%0d", k), 64'(grant_log[k]), 64'(k % 4));
        drain();

        // After grant 1 only req2/3 remain -> next grant 2.
        Reset = 1'b0;
        req_valid = '1;
        do_reset();
        for (int i = 0; i < 200 && grant_log.size() < 2; i++) step();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        for (int i = 0; i < 200 && grant_log.size() < 3; i++) step();
        req_valid = '0;
        check("skip_count", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() >= 3) begin
            check("skip_grant0", 64'(grant_log[0]), 64'(0));
            check("skip_grant1", 64'(grant_log[1]), 64'(1));
            check("skip_grant2", 64'(grant_log[2]), 64'(2));
        end
        drain();

        // Backpressure on requester 1; other resp_ready bits high are ignored.
        do_reset();
        resp_ready = 4'b1101;
        set_req(1, 32'd7, 32'd9, 1'b1);
        wait_grant(1, "bp_grant");
        req_valid[1] = 1'b0;
        set_req(0, 32'd4, 32'd4, 1'b1);
        wait_resp(40, lat, nload);
        check("bp_first_valid", 64'(s_resp_valid), 64'(4'b0010));
        check("bp_first_product", s_resp_product, 64'd63);
        held = s_resp_product;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_valid", 64'(s_resp_valid), 64'(4'b0010));
            check("bp_hold_product", s_resp_product, held);
            check("bp_hold_no_grant", 64'(s_req_ready), 64'(0));
        end
        resp_ready = '1;
        step();
        check("bp_release_no_grant", 64'(s_req_ready), 64'(0));
        wait_grant(0, "bp_next_grant");
        req_valid[0] = 1'b0;
        drain();

        // Reset in the middle of WAIT aborts the job.
        do_reset();
        stuck = 1'b1;
        set_req(1, 32'd11, 32'd13, 1'b1);
        wait_grant(1, "rst_grant");
        req_valid[1] = 1'b0;
        repeat (6) step();
        check("rst_in_wait_run", 64'(s_mul_run), 64'(1));
        set_req(0, 32'd2, 32'd21, 1'b1);
        set_req(3, 32'd5, 32'd6, 1'b1);
        Reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        sb.delete();
        stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_resp_valid", 64'(resp_valid), 64'(0));
        Reset = 1'b1;
        grant_log.delete();
        wait_grant(0, "rst_after_grant");
        req_valid = '0;
        if (grant_log.size() > 0) check("rst_first_owner", 64'(grant_log[0]), 64'(0));
        drain();

        // Multiplier that never finishes.
        stuck = 1'b1;
`ifdef MUL_ARB_WATCHDOG_EN
        expect_timeout = 1'b1;
        set_req(2, 32'd8, 32'd8, 1'b1);
        wait_grant(2, "wd_grant");
        req_valid[2] = 1'b0;
        expect_timeout = 1'b0;
        wait_resp(100, lat, nload);
        check("wd_latency", 64'(lat), 64'(3 + TIMEOUT));
        check("wd_resp_valid", 64'(s_resp_valid), 64'(4'b0100));
        check("wd_err", 64'(s_resp_err), 64'(1));
        check("wd_product", s_resp_product, 64'(0));
        check("wd_quiesce_load", 64'(s_mul_load), 64'(1));
        stuck = 1'b0;
        drain();
`else
        set_req(2, 32'd8, 32'd8, 1'b1);
        wait_grant(2, "nowd_grant");
        req_valid[2] = 1'b0;
        wait_resp(200, lat, nload);
        check("nowd_no_resp", 64'(lat), 64'(-1));
        check("nowd_still_run", 64'(s_mul_run), 64'(1));
        check("nowd_err", 64'(resp_err), 64'(0));
        do_reset();
        stuck = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_share_arbiter
